// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register.
// Bytes arrive LSB first. A completed byte waits in data_o until read_i
// consumes it. Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int FREQ = 27000000,
    parameter int BAUD = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       read_i,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int DIV = (FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_m, rx_s, rx_q;
    logic          start_edge, tick;

    // A falling edge on the synchronized line marks a candidate start bit.
    assign start_edge = rx_q & ~rx_s;
    assign tick       = (state != IDLE) && (cnt == '0);

    // Two-flop synchronizer plus one delayed copy; resets high so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= uart_rx_i;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // Frame FSM, bit timer, shift register and holding-register delivery.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            // A consume with no concurrent delivery empties the buffer.
            if (read_i && valid_o) valid_o <= 1'b0;
            if (state != IDLE && !tick) cnt <= cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        cnt   <= HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= FULL;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                        end else if (!valid_o || read_i) begin
                            // Same-cycle read frees the slot for the new byte.
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 16: table of whole frames plus
// hand-written sequences for glitch, read and mid-frame reset.
module tb_uart_rx;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       uart_rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       read_i;
    logic       frame_err_o;
    logic       overrun_o;

    int tests = 0;
    int fails = 0;

    // Per-frame observations, gathered at negedges inside send_frame.
    int fe_cyc, ov_cyc, both_cyc, vlow_cyc, rise_c;

    uart_rx #(.FREQ(1600), .BAUD(100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i),
        .data_o(data_o), .valid_o(valid_o), .read_i(read_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       pre_read;
        bit [7:0] data;
        bit       stop;
        bit       rd_at_stop;
        bit       exp_valid;
        bit [7:0] exp_data;
        int       exp_fe;
        int       exp_ov;
        int       exp_rise;   // -1: not checked
        int       exp_vlow;   // -1: not checked
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
    endtask

    // One-cycle read pulse; returns at the negedge after the sampling edge.
    task automatic read_pulse;
        read_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        read_i = 1'b0;
    endtask

    // Drives 160 bit-cycles of a frame starting at a negedge. Cycle c is
    // driven before posedge c+1. With the 2-flop sync the FSM sees the edge
    // at posedge 3, start tick at 11, data ticks at 27+16j, stop tick at 155;
    // so delivery is visible after posedge 155 (c = 154) and read_i must be
    // driven at c = 154 to land in the delivery cycle. abort_at >= 0 applies
    // a 2-cycle reset at that cycle and ends the frame.
    task automatic send_frame(input bit [7:0] d, input bit stop, input bit rd,
                              input int abort_at);
        bit v0;
        int idx;
        fe_cyc = 0; ov_cyc = 0; both_cyc = 0; vlow_cyc = 0; rise_c = -1;
        v0 = valid_o;
        for (int c = 0; c < 160; c++) begin
            idx = c / 16;
            if (idx == 0)      uart_rx_i = 1'b0;
            else if (idx <= 8) uart_rx_i = d[idx-1];
            else               uart_rx_i = stop;
            read_i = rd && (c == 154);
            if (c == abort_at) begin
                rst_i = 1'b1;
                uart_rx_i = 1'b1;
                idle(2);
                rst_i = 1'b0;
                break;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            fe_cyc += int'(frame_err_o);
            ov_cyc += int'(overrun_o);
            both_cyc += int'(frame_err_o & overrun_o);
            vlow_cyc += int'(!valid_o);
            if (!v0 && valid_o && rise_c < 0) rise_c = c;
        end
        read_i = 1'b0;
        uart_rx_i = 1'b1;
    endtask

    initial begin
        //          pre data  stp rd  v  data  fe ov rise vlow
        vecs[0] = '{0, 8'h55, 1, 0, 1, 8'h55, 0, 0, 154, -1};
        vecs[1] = '{1, 8'hA3, 0, 0, 0, 8'h55, 1, 0,  -1, -1};
        vecs[2] = '{0, 8'h5A, 1, 0, 1, 8'h5A, 0, 0,  -1, -1};
        vecs[3] = '{1, 8'h12, 1, 0, 1, 8'h12, 0, 0,  -1, -1};
        vecs[4] = '{0, 8'h34, 1, 0, 1, 8'h12, 0, 1,  -1, -1};
        vecs[5] = '{1, 8'h12, 1, 0, 1, 8'h12, 0, 0,  -1, -1};
        vecs[6] = '{0, 8'h34, 1, 1, 1, 8'h34, 0, 0,  -1,  0};

        rst_i = 1'b1; uart_rx_i = 1'b1; read_i = 1'b0;
        @(negedge clk_i);
        idle(3);
        chk("reset data_o", 32'(data_o), 32'h0);
        chk("reset valid_o", 32'(valid_o), 32'h0);
        chk("reset frame_err_o", 32'(frame_err_o), 32'h0);
        chk("reset overrun_o", 32'(overrun_o), 32'h0);
        rst_i = 1'b0;
        idle(5);
        chk("no start after reset valid", 32'(valid_o), 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].pre_read) read_pulse();
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].rd_at_stop, -1);
            idle(8);
            chk($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d data_o", i), 32'(data_o), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d frame_err cycles", i), 32'(fe_cyc), 32'(vecs[i].exp_fe));
            chk($sformatf("vec%0d overrun cycles", i), 32'(ov_cyc), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d err+ovr same cycle", i), 32'(both_cyc), 32'h0);
            if (vecs[i].exp_rise >= 0)
                chk($sformatf("vec%0d valid rise cycle", i), 32'(rise_c), 32'(vecs[i].exp_rise));
            if (vecs[i].exp_vlow >= 0)
                chk($sformatf("vec%0d valid low cycles", i), 32'(vlow_cyc), 32'(vecs[i].exp_vlow));
        end

        // Read with no delivery: valid_o drops next cycle, data_o holds.
        read_pulse();
        chk("read clears valid_o", 32'(valid_o), 32'h0);
        chk("read keeps data_o", 32'(data_o), 32'h34);
        idle(3);
        chk("read ignored when empty", 32'(valid_o), 32'h0);

        // 4-cycle glitch: rejected by the start-bit check.
        uart_rx_i = 1'b0;
        idle(4);
        uart_rx_i = 1'b1;
        fe_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            fe_cyc += int'(frame_err_o | overrun_o | valid_o);
        end
        chk("glitch no output activity", 32'(fe_cyc), 32'h0);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(8);
        chk("post-glitch valid_o", 32'(valid_o), 32'h1);
        chk("post-glitch data_o", 32'(data_o), 32'h0F);
        chk("post-glitch pulses", 32'(fe_cyc + ov_cyc), 32'h0);

        // Reset during data bit 4 of 0x81 (c = 16*5 + 8).
        send_frame(8'h81, 1'b1, 1'b0, 88);
        chk("midreset data_o", 32'(data_o), 32'h0);
        chk("midreset valid_o", 32'(valid_o), 32'h0);
        fe_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            fe_cyc += int'(frame_err_o | overrun_o | valid_o);
        end
        chk("midreset no pulse/valid", 32'(fe_cyc), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(8);
        chk("after reset valid_o", 32'(valid_o), 32'h1);
        chk("after reset data_o", 32'(data_o), 32'hC3);
        chk("after reset pulses", 32'(fe_cyc + ov_cyc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
